// File: rtl/acc_sched_pkg.sv
// Shared types and default widths for the round-robin accumulator scheduler.
package acc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int IN_W_DEF  = 4;
  localparam int ACC_W_DEF = 5;

endpackage

// File: rtl/acc_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr_i, wrapping.
// Produces a one-hot grant, its encoded index, and a flag that something was picked.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/acc_rr_scheduler.sv
// Round-robin scheduler sharing one wrapping accumulator among NREQ operand streams.
// Grant takes one IDLE cycle; result/ovf/done appear the cycle after the last operand.
module acc_rr_scheduler
  import acc_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IN_W-1:0] in_flat,
  input  logic [NREQ-1:0]      in_valid,
  input  logic [NREQ-1:0]      in_last,
  output logic [NREQ-1:0]      in_ready,
  output logic [NREQ-1:0]      gnt,
  output logic [ACC_W-1:0]     acc,
  output logic [ACC_W-1:0]     result,
  output logic                 ovf,
  output logic [NREQ-1:0]      done
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int SUM_W = ACC_W + 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               cy_q, cy_d;
  logic               ovf_q, ovf_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic [IN_W-1:0]    op;
  logic               op_vld;
  logic               op_last;
  logic [SUM_W-1:0]   sum;
  logic [IDX_W-1:0]   ptr_inc;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign op      = in_flat[idx_q*IN_W +: IN_W];
  assign op_vld  = in_valid[idx_q];
  assign op_last = in_last[idx_q];
  assign sum     = {1'b0, acc_q} + SUM_W'(op);
  assign ptr_inc = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    cy_d     = cy_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = BUSY;
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          acc_d   = '0;
          cy_d    = 1'b0;
        end
      end
      BUSY: begin
        // A valid last beats a simultaneous request drop.
        if (op_vld && op_last) begin
          state_d  = DONE;
          acc_d    = sum[ACC_W-1:0];
          result_d = sum[ACC_W-1:0];
          ovf_d    = cy_q | sum[ACC_W];
        end else if (!req[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_inc;
        end else if (op_vld) begin
          acc_d = sum[ACC_W-1:0];
          cy_d  = cy_q | sum[ACC_W];
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = ptr_inc;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cy_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cy_q     <= cy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign gnt      = gnt_q;
  assign in_ready = (state_q == BUSY) ? gnt_q : '0;
  assign done     = (state_q == DONE) ? gnt_q : '0;
  assign acc      = acc_q;
  assign result   = result_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_acc_rr_scheduler.sv
// Bench for acc_rr_scheduler: a stream-level reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_acc_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int IN_W  = 4;
  localparam int ACC_W = 5;
  localparam int MODV  = 1 << ACC_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*IN_W-1:0] in_flat = '0;
  logic [NREQ-1:0]      in_valid = '0;
  logic [NREQ-1:0]      in_last = '0;
  logic [NREQ-1:0]      in_ready;
  logic [NREQ-1:0]      gnt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     result;
  logic                 ovf;
  logic [NREQ-1:0]      done;

  int vectors = 0;
  int miscompares = 0;

  acc_rr_scheduler #(.NREQ(NREQ), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .in_flat  (in_flat),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .gnt      (gnt),
    .acc      (acc),
    .result   (result),
    .ovf      (ovf),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference model: owner = granted requester (-1 none), fin = in the done cycle,
  // sum = true unbounded sum of the current stream.
  int m_owner  = -1;
  bit m_fin    = 1'b0;
  int m_ptr    = 0;
  int m_sum    = 0;
  int m_result = 0;
  bit m_ovf    = 1'b0;

  always @(posedge clk or posedge rst) begin
    int n_owner, n_ptr, n_sum, n_result, j, opv;
    bit n_fin, n_ovf;
    if (rst) begin
      m_owner <= -1; m_fin <= 1'b0; m_ptr <= 0; m_sum <= 0; m_result <= 0; m_ovf <= 1'b0;
    end else begin
      n_owner = m_owner; n_fin = m_fin; n_ptr = m_ptr; n_sum = m_sum;
      n_result = m_result; n_ovf = m_ovf;
      if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (n_owner < 0 && req[j]) n_owner = j;
        end
        if (n_owner >= 0) n_sum = 0;
      end else if (m_fin) begin
        n_fin   = 1'b0;
        n_ptr   = (m_owner + 1) % NREQ;
        n_owner = -1;
      end else begin
        opv = int'(in_flat[m_owner*IN_W +: IN_W]);
        if (in_valid[m_owner] && in_last[m_owner]) begin
          n_sum    = m_sum + opv;
          n_fin    = 1'b1;
          n_result = n_sum % MODV;
          n_ovf    = (n_sum >= MODV);
        end else if (!req[m_owner]) begin
          n_ptr   = (m_owner + 1) % NREQ;
          n_owner = -1;
        end else if (in_valid[m_owner]) begin
          n_sum = m_sum + opv;
        end
      end
      m_owner <= n_owner; m_fin <= n_fin; m_ptr <= n_ptr; m_sum <= n_sum;
      m_result <= n_result; m_ovf <= n_ovf;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int oh;
    if (!rst) begin
      oh = (m_owner >= 0) ? (1 << m_owner) : 0;
      chk("model_gnt", int'(gnt), oh);
      chk("model_in_ready", int'(in_ready), (m_owner >= 0 && !m_fin) ? oh : 0);
      chk("model_done", int'(done), m_fin ? oh : 0);
      chk("model_acc", int'(acc), m_sum % MODV);
      chk("model_result", int'(result), m_result);
      chk("model_ovf", int'(ovf), int'(m_ovf));
    end
  end

  task automatic set_op(input int r, input int v, input bit last);
    in_flat[r*IN_W +: IN_W] = IN_W'(v);
    in_valid[r] = 1'b1;
    in_last[r]  = last;
    @(negedge clk);
    in_valid = '0;
    in_last  = '0;
  endtask

  task automatic wait_ready(input int r);
    int n = 0;
    while (!in_ready[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[r]) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ready%0d: in_ready=%b after %0d cycles, required bit %0d high", r, in_ready, n, r);
    end
  endtask

  initial begin
    int q[$];
    int exp_order[5] = '{0, 1, 3, 0, 1};
    int n, cyc, idx;

    // Reset and idle
    #100;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_done", int'(done), 0);

    // Single stream: 3 + 4
    req = 4'b0001;
    wait_ready(0);
    chk("single_gnt", int'(gnt), 1);
    set_op(0, 3, 1'b0);
    set_op(0, 4, 1'b1);
    chk("single_done", int'(done), 1);
    chk("single_result", int'(result), 7);
    chk("single_ovf", int'(ovf), 0);
    req = '0;
    @(negedge clk);
    chk("single_done_gone", int'(done), 0);

    // Overflow with a bubble: 15, -, 15, 15 -> 45 mod 32
    req = 4'b0010;
    wait_ready(1);
    set_op(1, 15, 1'b0);
    chk("ovf_acc1", int'(acc), 15);
    @(negedge clk);
    chk("ovf_bubble_acc", int'(acc), 15);
    set_op(1, 15, 1'b0);
    chk("ovf_acc2", int'(acc), 30);
    set_op(1, 15, 1'b1);
    chk("ovf_done", int'(done), 2);
    chk("ovf_result", int'(result), 13);
    chk("ovf_flag", int'(ovf), 1);
    req = '0;
    @(negedge clk);

    // Round-robin over 1011 with fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_start_gnt", int'(gnt), 0);
    in_flat  = 16'h1111;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    req      = 4'b1011;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done != 0) begin
        idx = -1;
        for (int b = 0; b < NREQ; b++) if (done[b]) idx = b;
        q.push_back(idx);
        chk("rr_result", int'(result), 1);
        n++;
      end
    end
    req = '0;
    in_valid = '0;
    in_last = '0;
    chk("rr_count", q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order%0d", i), (i < q.size()) ? q[i] : -1, exp_order[i]);
    @(negedge clk);

    // Abort on requester 2, then requester 3 takes over
    req = 4'b1100;
    wait_ready(2);
    set_op(2, 5, 1'b0);
    chk("abort_acc", int'(acc), 5);
    req = 4'b1000;
    @(negedge clk);
    chk("abort_done", int'(done), 0);
    chk("abort_gnt", int'(gnt), 0);
    chk("abort_result", int'(result), 1);
    @(negedge clk);
    chk("abort_next_gnt", int'(gnt), 8);
    wait_ready(3);
    set_op(3, 2, 1'b1);
    chk("after_abort_done", int'(done), 8);
    chk("after_abort_result", int'(result), 2);
    req = '0;
    @(negedge clk);

    // Asynchronous reset in the middle of a stream
    req = 4'b0001;
    wait_ready(0);
    set_op(0, 9, 1'b0);
    set_op(0, 2, 1'b0);
    chk("mid_acc", int'(acc), 11);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", int'(acc), 0);
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_result", int'(result), 0);
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_gnt", int'(gnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
